scan_result_writer: RTL and testbench

Write-back end of the scan pipeline. Accepts the per-pixel result stream the edge detector produces while the image is read in one of four scan orders, regenerates the matching pixel address for every accepted sample and writes the result into the N×N result memory. It checks the detector's end-of-line markers against its own line tracking. With merging compiled in, it combines results from successive passes by taking the maximum.

---
 rtl/scan_result_writer_if.sv | 26 ++
 rtl/scan_result_writer.sv | 216 +++++++++++++++++++++
 tb/tb_scan_result_writer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_result_writer_if.sv
// Result-stream and memory-port bundle for scan_result_writer.
// slave = the writer, master = the detector/memory side.
interface scan_result_writer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 15
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic [ADDR_W-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;

   modport master (
      output in_valid, in_data, in_last, mem_rdata,
      input  in_ready, mem_raddr, mem_waddr, mem_wdata, mem_we
   );

   modport slave (
      input  in_valid, in_data, in_last, mem_rdata,
      output in_ready, mem_raddr, mem_waddr, mem_wdata, mem_we
   );
endinterface

// File: rtl/scan_result_writer.sv
// Scan-order result writer: regenerates pixel addresses for LR/UD/DL/DR.
// Optional EDGE_MERGE_EN: write max(old memory value, new sample).
module scan_result_writer #(
   parameter int N      = 150,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 15
) (
   input  logic                clk,
   input  logic                resetIn,
   input  logic                start,
   input  logic [1:0]          mode,
   scan_result_writer_if.slave bus,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(N * N + 1);

   localparam logic [1:0] M_LR = 2'b00;
   localparam logic [1:0] M_UD = 2'b01;
   localparam logic [1:0] M_DL = 2'b10;
   localparam logic [1:0] M_DR = 2'b11;

   localparam logic [PW-1:0] PMAX     = PW'(N - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N * N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      LAST
   } state_t;

   state_t            state;
   logic [1:0]        mode_q;
   logic [PW-1:0]     row;
   logic [PW-1:0]     col;
   logic [PW-1:0]     srow;
   logic [PW-1:0]     scol;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] waddr_q;
   logic              we_q;
   logic              ready_q;
   logic              done_q;
   logic              busy_q;
   logic              err_q;

   logic              accept;
   logic              at_end;
   logic              row_end;
   logic              col_end;
   logic              col_zero;
   logic [PW-1:0]     nrow;
   logic [PW-1:0]     ncol;
   logic [PW-1:0]     nsrow;
   logic [PW-1:0]     nscol;
   logic [ADDR_W-1:0] addr;

   assign accept = (state == RUN) && ready_q && bus.in_valid;

   // full-width address of the current position
   assign addr = ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);

   // line-end detection and next position for the latched scan order;
   // diagonal orders step the line start (srow,scol) along the border
   always_comb begin
      row_end  = (row == PMAX);
      col_end  = (col == PMAX);
      col_zero = (col == '0);
      at_end   = 1'b0;
      nrow     = row;
      ncol     = col;
      nsrow    = srow;
      nscol    = scol;
      unique case (mode_q)
         M_LR: begin
            at_end = col_end;
            if (at_end) begin
               nrow = row + 1'b1;
               ncol = '0;
            end else begin
               ncol = col + 1'b1;
            end
         end
         M_UD: begin
            at_end = row_end;
            if (at_end) begin
               nrow = '0;
               ncol = col + 1'b1;
            end else begin
               nrow = row + 1'b1;
            end
         end
         M_DL: begin
            at_end = row_end || col_zero;
            if (at_end) begin
               if (scol != PMAX) begin
                  nscol = scol + 1'b1;
               end else begin
                  nsrow = srow + 1'b1;
               end
               nrow = nsrow;
               ncol = nscol;
            end else begin
               nrow = row + 1'b1;
               ncol = col - 1'b1;
            end
         end
         M_DR: begin
            at_end = row_end || col_end;
            if (at_end) begin
               if (scol != '0) begin
                  nscol = scol - 1'b1;
               end else begin
                  nsrow = srow + 1'b1;
               end
               nrow = nsrow;
               ncol = nscol;
            end else begin
               nrow = row + 1'b1;
               ncol = col + 1'b1;
            end
         end
         default: begin
            at_end = 1'b0;
         end
      endcase
   end

   // pass FSM with position tracking and registered write port
   always_ff @(posedge clk) begin
      if (resetIn) begin
         state   <= IDLE;
         mode_q  <= M_LR;
         row     <= '0;
         col     <= '0;
         srow    <= '0;
         scol    <= '0;
         cnt     <= '0;
         data_q  <= '0;
         waddr_q <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  err_q   <= 1'b0;
                  cnt     <= '0;
                  row     <= '0;
                  srow    <= '0;
                  col     <= (mode == M_DR) ? PMAX : '0;
                  scol    <= (mode == M_DR) ? PMAX : '0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  we_q    <= 1'b1;
                  waddr_q <= addr;
                  data_q  <= bus.in_data;
                  row     <= nrow;
                  col     <= ncol;
                  srow    <= nsrow;
                  scol    <= nscol;
                  cnt     <= cnt + 1'b1;
                  if (bus.in_last != at_end) begin
                     err_q <= 1'b1;
                  end
                  if (cnt == CNT_LAST) begin
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
                     state   <= LAST;
                  end
               end
            end
            LAST: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_waddr = waddr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

`ifdef EDGE_MERGE_EN
   // read the pixel being accepted; merge once its data returns
   assign bus.mem_raddr = addr;
   assign bus.mem_wdata = (bus.mem_rdata > data_q) ? bus.mem_rdata : data_q;
`else
   logic unused_rdata;

   // plain overwrite; the read port is parked
   assign bus.mem_raddr = '0;
   assign bus.mem_wdata = data_q;
   assign unused_rdata  = ^bus.mem_rdata;
`endif
endmodule

// File: tb/tb_scan_result_writer.sv
// Bench for scan_result_writer: scoreboard of expected writes per scan order.
// Build with +define+EDGE_MERGE_EN to exercise the merge variant.
module tb_scan_result_writer;
   localparam int N  = 150;
   localparam int DW = 8;
   localparam int AW = 15;
   localparam int NN = N * N;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          fin;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetIn;
   logic       start;
   logic [1:0] mode;
   logic       busy;
   logic       done;
   logic       err;

   scan_result_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   scan_result_writer #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk     (clk),
      .resetIn (resetIn),
      .start   (start),
      .mode    (mode),
      .bus     (bus.slave),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram    [1 << AW] = '{default: '0};
   logic [DW-1:0] shadow [1 << AW] = '{default: '0};
   logic          pl_we = 1'b0;
   logic [AW-1:0] pl_a  = '0;
   logic [DW-1:0] pl_d  = '0;

   int   ord [NN];
   bit   lst [NN];
   exp_t q [$];
   exp_t mon_e;
   int   nchk  = 0;
   int   npass = 0;
   int   ndone = 0;
   logic [7:0] salt  = 8'h00;
   bit         dfix  = 1'b0;
   logic [7:0] dfix0 = 8'h00;
   logic [7:0] dfix1 = 8'h00;

   // result memory with one-cycle read latency
   always @(posedge clk) begin
`ifdef EDGE_MERGE_EN
      bus.mem_rdata <= ram[bus.mem_raddr];
`else
      bus.mem_rdata <= DW'($urandom);
`endif
      if (pl_we) ram[pl_a] <= pl_d;
      else if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
   end

   // scoreboard: every write must match the oldest pending accept
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         if (q.size() == 0) begin
            nchk++;
            $display("FAIL write_unexpected: addr %0d with nothing pending", bus.mem_waddr);
         end else begin
            mon_e = q.pop_front();
            nchk++;
            if (bus.mem_waddr !== mon_e.a)
               $display("FAIL wr_addr: got %0d want %0d", bus.mem_waddr, mon_e.a);
            else npass++;
            nchk++;
            if (bus.mem_wdata !== mon_e.d)
               $display("FAIL wr_data@%0d: got %h want %h", mon_e.a, bus.mem_wdata, mon_e.d);
            else npass++;
            nchk++;
            if (done !== mon_e.fin)
               $display("FAIL wr_done@%0d: got %b want %b", mon_e.a, done, mon_e.fin);
            else npass++;
         end
      end else if (done !== 1'b0) begin
         nchk++;
         $display("FAIL done_no_write: got done=%b want 0", done);
      end
      if (done === 1'b1) ndone++;
   end

   task automatic build_order(input logic [1:0] m);
      int i = 0;
      int lo;
      int hi;
      case (m)
         2'b00:
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++) begin
                  ord[i] = r * N + c; lst[i] = (c == N - 1); i++;
               end
         2'b01:
            for (int c = 0; c < N; c++)
               for (int r = 0; r < N; r++) begin
                  ord[i] = r * N + c; lst[i] = (r == N - 1); i++;
               end
         2'b10:
            for (int d = 0; d <= 2 * N - 2; d++) begin
               lo = (d - N + 1 > 0) ? d - N + 1 : 0;
               hi = (d < N - 1) ? d : N - 1;
               for (int r = lo; r <= hi; r++) begin
                  ord[i] = r * N + (d - r); lst[i] = (r == hi); i++;
               end
            end
         default:
            for (int k = N - 1; k >= -(N - 1); k--) begin
               lo = (-k > 0) ? -k : 0;
               hi = (N - 1 - k < N - 1) ? N - 1 - k : N - 1;
               for (int r = lo; r <= hi; r++) begin
                  ord[i] = r * N + (r + k); lst[i] = (r == hi); i++;
               end
            end
      endcase
   endtask

   // feed samples [from,upto) with gap% idle cycles; bad flips in_last
   task automatic drive(input int from, input int upto, input int gap, input int bad);
      int i = from;
      int cyc = 0;
      logic [DW-1:0] d;
      exp_t e;
      while (i < upto && cyc < 4 * (upto - from) + 100) begin
         bus.in_valid = ($urandom_range(99) >= gap);
         d = ord[i][7:0] ^ salt;
         if (dfix && i == 0) d = dfix0;
         if (dfix && i == 1) d = dfix1;
         bus.in_data = d;
         bus.in_last = lst[i] ^ (i == bad);
         mode = 2'($urandom);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready && !resetIn) begin
            e.a = AW'(ord[i]);
`ifdef EDGE_MERGE_EN
            e.d = (shadow[ord[i]] > d) ? shadow[ord[i]] : d;
`else
            e.d = d;
`endif
            shadow[ord[i]] = e.d;
            e.fin = (i == NN - 1);
            q.push_back(e);
            i++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (i < upto) begin
         nchk++;
         $display("FAIL drive_timeout: accepted %0d want %0d", i - from, upto - from);
      end
   endtask

   task automatic do_start(input logic [1:0] m);
      mode  = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset;
      resetIn = 1'b1;
      start = 1'b0;
      mode = 2'b00;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nchk++; if (bus.in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.in_ready); else npass++;
      nchk++; if (bus.mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.mem_we); else npass++;
      nchk++; if (bus.mem_waddr !== '0) $display("FAIL rst_waddr: got %0d want 0", bus.mem_waddr); else npass++;
      nchk++; if (bus.mem_wdata !== '0) $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); else npass++;
      nchk++; if (bus.mem_raddr !== '0) $display("FAIL rst_raddr: got %0d want 0", bus.mem_raddr); else npass++;
      nchk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else npass++;
      nchk++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else npass++;
      nchk++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else npass++;
      resetIn = 1'b0;
      @(posedge clk); #1;
      nchk++; if (bus.in_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", bus.in_ready); else npass++;
   endtask

   task automatic test_lr_err;
      int d0 = ndone;
      build_order(2'b00);
      salt = 8'h00;
      do_start(2'b00);
      nchk++; if (bus.in_ready !== 1'b1) $display("FAIL lr_ready: got %b want 1", bus.in_ready); else npass++;
      nchk++; if (busy !== 1'b1) $display("FAIL lr_busy: got %b want 1", busy); else npass++;
      drive(0, 4, 15, -1);
      nchk++; if (err !== 1'b0) $display("FAIL lr_err_pre: got %b want 0", err); else npass++;
      drive(4, 5, 15, 4);
      nchk++; if (err !== 1'b1) $display("FAIL lr_err_set: got %b want 1", err); else npass++;
      drive(5, NN, 15, -1);
      nchk++; if (bus.mem_waddr !== AW'(NN - 1)) $display("FAIL lr_last_addr: got %0d want %0d", bus.mem_waddr, NN - 1); else npass++;
      nchk++; if (busy !== 1'b1) $display("FAIL lr_busy_done: got %b want 1", busy); else npass++;
      @(posedge clk); #1;
      nchk++; if (busy !== 1'b0) $display("FAIL lr_busy_end: got %b want 0", busy); else npass++;
      repeat (3) @(posedge clk);
      #1;
      nchk++; if (ndone - d0 != 1) $display("FAIL lr_done_count: got %0d want 1", ndone - d0); else npass++;
      nchk++; if (err !== 1'b1) $display("FAIL lr_err_held: got %b want 1", err); else npass++;
      nchk++; if (q.size() != 0) $display("FAIL lr_pending: got %0d want 0", q.size()); else npass++;
   endtask

   task automatic test_dl;
      int d0 = ndone;
      build_order(2'b10);
      salt = 8'($urandom);
      do_start(2'b10);
      nchk++; if (err !== 1'b0) $display("FAIL dl_err_clear: got %b want 0", err); else npass++;
      drive(0, 6, 0, -1);
`ifdef EDGE_MERGE_EN
      nchk++; if (bus.mem_raddr !== AW'(ord[6])) $display("FAIL dl_raddr: got %0d want %0d", bus.mem_raddr, ord[6]); else npass++;
`else
      nchk++; if (bus.mem_raddr !== '0) $display("FAIL dl_raddr: got %0d want 0", bus.mem_raddr); else npass++;
`endif
      drive(6, NN, 0, -1);
      nchk++; if (bus.mem_waddr !== AW'(NN - 1)) $display("FAIL dl_last_addr: got %0d want %0d", bus.mem_waddr, NN - 1); else npass++;
      nchk++; if (done !== 1'b1) $display("FAIL dl_done: got %b want 1", done); else npass++;
      repeat (3) @(posedge clk);
      #1;
      nchk++; if (ndone - d0 != 1) $display("FAIL dl_done_count: got %0d want 1", ndone - d0); else npass++;
      nchk++; if (err !== 1'b0) $display("FAIL dl_err: got %b want 0", err); else npass++;
   endtask

   task automatic test_dr;
      build_order(2'b11);
      salt = 8'($urandom);
      do_start(2'b11);
      drive(0, 1000, 5, -1);
      mode = 2'b00;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nchk++; if (busy !== 1'b1) $display("FAIL dr_restart_busy: got %b want 1", busy); else npass++;
      nchk++; if (bus.in_ready !== 1'b1) $display("FAIL dr_restart_ready: got %b want 1", bus.in_ready); else npass++;
      drive(1000, NN, 5, -1);
      nchk++; if (bus.mem_waddr !== AW'((N - 1) * N)) $display("FAIL dr_last_addr: got %0d want %0d", bus.mem_waddr, (N - 1) * N); else npass++;
      nchk++; if (done !== 1'b1) $display("FAIL dr_done: got %b want 1", done); else npass++;
      repeat (3) @(posedge clk);
      #1;
      nchk++; if (err !== 1'b0) $display("FAIL dr_err: got %b want 0", err); else npass++;
   endtask

   task automatic test_ud_reset;
      build_order(2'b01);
      salt = 8'($urandom);
      do_start(2'b01);
      drive(0, 400, 0, -1);
      nchk++; if (err !== 1'b0) $display("FAIL ud_err: got %b want 0", err); else npass++;
      resetIn = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      resetIn = 1'b0;
      bus.in_valid = 1'b0;
      nchk++; if (bus.mem_we !== 1'b0) $display("FAIL ud_rst_we: got %b want 0", bus.mem_we); else npass++;
      nchk++; if (busy !== 1'b0) $display("FAIL ud_rst_busy: got %b want 0", busy); else npass++;
      nchk++; if (bus.in_ready !== 1'b0) $display("FAIL ud_rst_ready: got %b want 0", bus.in_ready); else npass++;
      nchk++; if (q.size() != 0) $display("FAIL ud_pending: got %0d want 0", q.size()); else npass++;
   endtask

   task automatic test_merge_reset;
      logic [7:0] w0;
      logic [7:0] w1;
      pl_we = 1'b1; pl_a = AW'(0); pl_d = 8'h80;
      @(posedge clk); #1;
      pl_a = AW'(1); pl_d = 8'h20;
      @(posedge clk); #1;
      pl_we = 1'b0;
      shadow[0] = 8'h80;
      shadow[1] = 8'h20;
`ifdef EDGE_MERGE_EN
      w0 = 8'h80;
`else
      w0 = 8'h10;
`endif
      w1 = 8'hF0;
      build_order(2'b00);
      salt = 8'h00;
      dfix = 1'b1; dfix0 = 8'h10; dfix1 = 8'hF0;
      do_start(2'b00);
      drive(0, 1, 0, -1);
      nchk++; if (bus.mem_wdata !== w0) $display("FAIL mg_wdata0: got %h want %h", bus.mem_wdata, w0); else npass++;
      drive(1, 2, 0, -1);
      nchk++; if (bus.mem_wdata !== w1) $display("FAIL mg_wdata1: got %h want %h", bus.mem_wdata, w1); else npass++;
      dfix = 1'b0;
      drive(2, 1000, 0, -1);
      resetIn = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      resetIn = 1'b0;
      bus.in_valid = 1'b0;
      nchk++; if (bus.mem_we !== 1'b0) $display("FAIL mg_rst_we: got %b want 0", bus.mem_we); else npass++;
      nchk++; if (busy !== 1'b0) $display("FAIL mg_rst_busy: got %b want 0", busy); else npass++;
      do_start(2'b00);
      drive(0, 3, 0, -1);
      nchk++; if (bus.mem_waddr !== AW'(2)) $display("FAIL mg_restart_addr: got %0d want 2", bus.mem_waddr); else npass++;
      @(negedge clk);
      resetIn = 1'b1;
      @(posedge clk); #1;
      resetIn = 1'b0;
      nchk++; if (q.size() != 0) $display("FAIL mg_pending: got %0d want 0", q.size()); else npass++;
   endtask

   initial begin
      test_reset();
      test_lr_err();
      test_dl();
      test_dr();
      test_ud_reset();
      test_merge_reset();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
